// File: rtl/dcp_mem_dump.sv
// Memory-dump command unit: scans a start address, reads N words and prints "addr-data" lines.
// Optional DCP_DUMP_CNT_EN adds a second scan that sets the word count of each dump.
module dcp_mem_dump #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int N_WORDS  = 8,
    parameter int RD_LAT   = 1,
    parameter int ADDR_INC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] end_addr,
    output logic          finish,
    output logic          req_scan,
    input  logic          ack_scan,
    input  logic [31:0]   din_scan,
    input  logic          flag_scan,
    output logic          req_print,
    input  logic          ack_print,
    output logic [31:0]   dout_print,
    output logic          type_print,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [3:0] {
        IDLE,
        SCAN_A,
`ifdef DCP_DUMP_CNT_EN
        SCAN_N,
`endif
        RD_ISSUE,
        RD_WAIT,
        PRT_A,
        PRT_D,
        NEXT,
        DONE
    } state_t;

    localparam logic [2:0]    LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [AW-1:0] INC      = AW'(ADDR_INC);

    state_t        state, state_n;
    logic [AW-1:0] cur_addr;
    logic [31:0]   data_q;
    logic [7:0]    cnt;
    logic [7:0]    target;
    logic [2:0]    lat_cnt;
    logic [8:0]    cnt_inc;
    logic          last_word;

    assign cnt_inc   = {1'b0, cnt} + 9'd1;
    assign last_word = (cnt_inc == {1'b0, target});
    assign mem_addr  = cur_addr;

`ifndef DCP_DUMP_CNT_EN
    assign target = 8'(N_WORDS);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_scan   = 1'b0;
        req_print  = 1'b0;
        mem_re     = 1'b0;
        finish     = 1'b0;
        dout_print = '0;
        type_print = 1'b0;
        case (state)
            IDLE:     if (we) state_n = SCAN_A;
            SCAN_A: begin
                req_scan = 1'b1;
`ifdef DCP_DUMP_CNT_EN
                if (ack_scan) state_n = SCAN_N;
            end
            SCAN_N: begin
                req_scan = 1'b1;
`endif
                if (ack_scan) state_n = RD_ISSUE;
            end
            RD_ISSUE: begin
                mem_re  = 1'b1;
                state_n = RD_WAIT;
            end
            RD_WAIT:  if (lat_cnt == LAT_LAST) state_n = PRT_A;
            PRT_A: begin
                req_print  = 1'b1;
                dout_print = 32'(cur_addr);
                if (ack_print) state_n = PRT_D;
            end
            PRT_D: begin
                req_print  = 1'b1;
                type_print = 1'b1;
                dout_print = data_q;
                if (ack_print) state_n = NEXT;
            end
            NEXT:     state_n = last_word ? DONE : RD_ISSUE;
            DONE: begin
                finish  = 1'b1;
                state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            data_q   <= '0;
            cnt      <= '0;
            lat_cnt  <= '0;
            end_addr <= '0;
`ifdef DCP_DUMP_CNT_EN
            target   <= 8'(N_WORDS);
`endif
        end else begin
            case (state)
                IDLE: if (we) begin
                    cnt <= '0;
`ifdef DCP_DUMP_CNT_EN
                    target <= 8'(N_WORDS);
`endif
                end
                SCAN_A: if (ack_scan)
                    cur_addr <= flag_scan ? last_addr + INC : AW'(din_scan);
`ifdef DCP_DUMP_CNT_EN
                // empty entry or a typed zero both fall back to the default length
                SCAN_N: if (ack_scan)
                    target <= (flag_scan || din_scan[7:0] == 8'd0) ? 8'(N_WORDS) : din_scan[7:0];
`endif
                RD_ISSUE: lat_cnt <= '0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_cnt == LAT_LAST) data_q <= 32'(mem_rdata);
                end
                NEXT: begin
                    end_addr <= cur_addr;
                    cnt      <= cnt_inc[7:0];
                    if (!last_word) cur_addr <= cur_addr + INC;
                end
                default: ;
            endcase
        end
    end

endmodule
